// File: rtl/anim_pkg.sv
// Shared types and constants for the sprite animation sequencer.
package anim_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int SPRITE_W   = 264;
  localparam int X_RESET    = 188;
  localparam int BASE_Y     = 160;
  localparam int BOB        = 5;
  localparam int PHASE_BITS = 2;

  // Horizontal limits of the sprite left edge, and the wrap distance.
  localparam logic signed [10:0] X_MAX    = 11'(H_ACTIVE - 1);
  localparam logic signed [10:0] X_MIN    = 11'(-SPRITE_W);
  localparam logic signed [10:0] X_SPAN   = 11'(H_ACTIVE + SPRITE_W);
  localparam logic signed [10:0] X_RST    = 11'(X_RESET);
  localparam logic [9:0]         Y_RST    = 10'(BASE_Y + BOB);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMMIT,
    ST_ADVANCE,
    ST_MOVE,
    ST_DONE
  } state_e;

  localparam logic [1:0] ADDR_SPEED   = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_DX      = 2'd2;
  localparam logic [1:0] ADDR_RESTART = 2'd3;

  // One complete configuration set, used for both shadow and active copies.
  typedef struct packed {
    logic [7:0]            speed;       // frames per phase, 0 holds
    logic                  run;
    logic                  step;        // one-shot advance request
    logic [PHASE_BITS-1:0] last_phase;
    logic [7:0]            dx;          // signed pixels per advance
    logic                  restart;     // one-shot x reload request
    logic [7:0]            restart_val; // x reloads to restart_val * 4
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    speed:       8'd16,
    run:         1'b1,
    step:        1'b0,
    last_phase:  PHASE_BITS'(1),
    dx:          8'd0,
    restart:     1'b0,
    restart_val: 8'd0
  };

  // Odd phases sit at the base line, even phases bob down.
  function automatic logic [9:0] y_for_phase(input logic [PHASE_BITS-1:0] phase);
    return phase[0] ? 10'(BASE_Y) : 10'(BASE_Y + BOB);
  endfunction

endpackage

// File: rtl/anim_sequencer_if.sv
// Frame/config inputs and renderer-facing outputs of the animation sequencer.
interface anim_sequencer_if;
  import anim_pkg::*;

  logic                  frame_start;
  logic                  cfg_we;
  logic [1:0]            cfg_addr;
  logic [7:0]            cfg_wdata;
  logic [PHASE_BITS-1:0] anim_phase;
  logic signed [10:0]    sprite_x;
  logic [9:0]            sprite_y;
  logic                  update;
  logic                  overrun;

  modport master (
    output frame_start, cfg_we, cfg_addr, cfg_wdata,
    input  anim_phase, sprite_x, sprite_y, update, overrun
  );

  modport slave (
    input  frame_start, cfg_we, cfg_addr, cfg_wdata,
    output anim_phase, sprite_x, sprite_y, update, overrun
  );

endinterface

// File: rtl/anim_cfg_regs.sv
// Shadow configuration registers with one-shot step/restart request flags.
module anim_cfg_regs
  import anim_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_we_i,
  input  logic [1:0] cfg_addr_i,
  input  logic [7:0] cfg_wdata_i,
  input  logic       consume_i,   // sequencer is copying shadow to active
  output cfg_t       shadow_o,
  output logic       ovr_clr_o    // write of 1 to the overrun-clear bit
);

  cfg_t shadow_q, shadow_d;

  // Next shadow value: consume one-shots first so a same-cycle write survives.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a path that skips the assignment infers a latch.
    shadow_d  = shadow_q;
    ovr_clr_o = 1'b0;
    if (consume_i) begin
      shadow_d.step    = 1'b0;
      shadow_d.restart = 1'b0;
    end
    if (cfg_we_i) begin
      case (cfg_addr_i)
        ADDR_SPEED: shadow_d.speed = cfg_wdata_i;
        ADDR_CTRL: begin
          shadow_d.run        = cfg_wdata_i[0];
          if (cfg_wdata_i[1]) shadow_d.step = 1'b1;
          shadow_d.last_phase = PHASE_BITS'(cfg_wdata_i[3:2]);
          ovr_clr_o           = cfg_wdata_i[7];
        end
        ADDR_DX: shadow_d.dx = cfg_wdata_i;
        ADDR_RESTART: begin
          shadow_d.restart     = 1'b1;
          shadow_d.restart_val = cfg_wdata_i;
        end
      endcase
    end
  end

  // Shadow register with synchronous reset to the default configuration.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of block ordering.
    if (!rst_n) shadow_q <= CFG_RST;
    else        shadow_q <= shadow_d;
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/anim_sequencer.sv
// Once-per-frame animation sequencer: advances phase and x, publishes atomically.
module anim_sequencer
  import anim_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  anim_sequencer_if.slave bus
);

  state_e                state_q, state_d;
  cfg_t                  shadow;
  cfg_t                  active_q, active_d;
  logic                  ovr_clr;
  logic [7:0]            div_q, div_d;
  logic [8:0]            div_inc;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic                  advanced_q, advanced_d;
  logic [PHASE_BITS-1:0] next_phase_q, next_phase_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic signed [10:0]    x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic                  update_q, update_d;
  logic signed [10:0]    dx_ext;
  logic signed [10:0]    x_step;
  logic signed [10:0]    x_moved;

  anim_cfg_regs u_cfg (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (bus.cfg_we),
    .cfg_addr_i  (bus.cfg_addr),
    .cfg_wdata_i (bus.cfg_wdata),
    .consume_i   (state_q == ST_COMMIT),
    .shadow_o    (shadow),
    .ovr_clr_o   (ovr_clr)
  );

  // Horizontal step with wrap-around so the sprite re-enters from the far side.
  always_comb begin
    dx_ext  = $signed({{3{active_q.dx[7]}}, active_q.dx});
    x_step  = x_q + dx_ext;
    x_moved = x_step;
    if (x_step > X_MAX)      x_moved = x_step - X_SPAN;
    else if (x_step < X_MIN) x_moved = x_step + X_SPAN;
  end

  // Sequencer FSM next-state, divider, phase/position and frame-overlap tracking.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    div_d        = div_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q & ~ovr_clr;
    advanced_d   = advanced_q;
    next_phase_d = next_phase_q;
    phase_d      = phase_q;
    x_d          = x_q;
    y_d          = y_q;
    update_d     = 1'b0;
    div_inc      = {1'b0, div_q} + 9'd1;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start || pending_q) begin
          pending_d = 1'b0;
          state_d   = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        active_d = shadow;
        state_d  = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        advanced_d = 1'b0;
        if (active_q.step) begin
          div_d      = 8'd0;
          advanced_d = 1'b1;
        end else if (active_q.run && active_q.speed != 8'd0) begin
          if (div_inc >= {1'b0, active_q.speed}) begin
            div_d      = 8'd0;
            advanced_d = 1'b1;
          end else begin
            div_d = div_inc[7:0];
          end
        end
        if (advanced_d) begin
          next_phase_d = (phase_q >= active_q.last_phase) ? '0 : PHASE_BITS'(phase_q + 1'b1);
        end else begin
          next_phase_d = phase_q;
        end
        state_d = ST_MOVE;
      end
      ST_MOVE: begin
        // Outputs load together on the edge into DONE, alongside the update pulse.
        phase_d = next_phase_q;
        y_d     = y_for_phase(next_phase_q);
        if (active_q.restart)  x_d = $signed({1'b0, active_q.restart_val, 2'b00});
        else if (advanced_q)   x_d = x_moved;
        update_d = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A frame arriving mid-sequence is queued once; any further one is lost.
    if (bus.frame_start && state_q != ST_IDLE) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      active_q     <= CFG_RST;
      div_q        <= 8'd0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      advanced_q   <= 1'b0;
      next_phase_q <= '0;
      phase_q      <= '0;
      x_q          <= X_RST;
      y_q          <= Y_RST;
      update_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      div_q        <= div_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      advanced_q   <= advanced_d;
      next_phase_q <= next_phase_d;
      phase_q      <= phase_d;
      x_q          <= x_d;
      y_q          <= y_d;
      update_q     <= update_d;
    end
  end

  assign bus.anim_phase = phase_q;
  assign bus.sprite_x   = x_q;
  assign bus.sprite_y   = y_q;
  assign bus.update     = update_q;
  assign bus.overrun    = overrun_q;

endmodule
